// File: rtl/axi_sram_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3 master.
// Each port has at most one transaction in flight; data reads wait for writes to drain.
module axi_sram_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t   r_ar_state;
  w_state_t    r_w_state;
  logic        r_inst_pend;
  logic        r_data_pend;

  logic        r_arvalid;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [1:0]  r_arsize;

  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic [31:0] r_awaddr;
  logic [1:0]  r_awsize;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic        w_ar_idle;
  logic        w_w_idle;
  logic        w_data_rd_grant;
  logic        w_inst_rd_grant;
  logic        w_data_wr_grant;
  logic        w_inst_rret;
  logic        w_data_rret;
  logic        w_bret;
  logic        w_ar_hs;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_unused;

  assign w_ar_idle = (r_ar_state == AR_IDLE);
  assign w_w_idle  = (r_w_state == W_IDLE);

  // Data reads only start with the write path idle so a load never overtakes a store.
  assign w_data_rd_grant = aresetn & w_ar_idle & w_w_idle & data_sram_req & ~data_sram_wr
                         & ~r_data_pend;
  assign w_inst_rd_grant = aresetn & w_ar_idle & ~w_data_rd_grant & inst_sram_req & ~r_inst_pend;
  assign w_data_wr_grant = aresetn & w_w_idle & data_sram_req & data_sram_wr & ~r_data_pend
                         & ~w_data_rd_grant;

  // A DATA_ID beat only counts as load data when the shared pend flag belongs to a read.
  assign w_inst_rret = rvalid & (rid == INST_ID) & r_inst_pend;
  assign w_data_rret = rvalid & (rid == DATA_ID) & r_data_pend & w_w_idle;
  assign w_bret      = (r_w_state == W_RESP) & r_bready & bvalid;

  assign w_ar_hs   = r_arvalid & arready;
  assign w_aw_done = ~r_awvalid | awready;
  assign w_w_done  = ~r_wvalid | wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_state <= AR_IDLE;
      r_arvalid  <= 1'b0;
    end else begin
      case (r_ar_state)
        AR_IDLE: begin
          if (w_data_rd_grant || w_inst_rd_grant) begin
            r_arvalid  <= 1'b1;
            r_ar_state <= AR_BUSY;
          end
        end
        AR_BUSY: begin
          if (w_ar_hs) begin
            r_arvalid  <= 1'b0;
            r_ar_state <= AR_IDLE;
          end
        end
        default: begin
          r_arvalid  <= 1'b0;
          r_ar_state <= AR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_data_rd_grant) begin
      r_arid   <= DATA_ID;
      r_araddr <= data_sram_addr;
      r_arsize <= data_sram_size;
    end else if (w_inst_rd_grant) begin
      r_arid   <= INST_ID;
      r_araddr <= inst_sram_addr;
      r_arsize <= inst_sram_size;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_w_state <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_data_wr_grant) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_w_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (r_awvalid && awready) r_awvalid <= 1'b0;
          if (r_wvalid && wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready  <= 1'b1;
            r_w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (w_bret) begin
            r_bready  <= 1'b0;
            r_w_state <= W_IDLE;
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_w_state <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_data_wr_grant) begin
      r_awaddr <= data_sram_addr;
      r_awsize <= data_sram_size;
      r_wstrb  <= data_sram_wstrb;
      r_wdata  <= data_sram_wdata;
    end
  end

  // Grant requires the flag clear, so a set and a clear never target the same master at once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_inst_pend <= 1'b0;
      r_data_pend <= 1'b0;
    end else begin
      if (w_inst_rd_grant)  r_inst_pend <= 1'b1;
      else if (w_inst_rret) r_inst_pend <= 1'b0;
      if (w_data_rd_grant || w_data_wr_grant) r_data_pend <= 1'b1;
      else if (w_data_rret || w_bret)         r_data_pend <= 1'b0;
    end
  end

  assign inst_sram_addr_ok = w_inst_rd_grant;
  assign inst_sram_data_ok = w_inst_rret;
  assign inst_sram_rdata   = rdata;
  assign data_sram_addr_ok = w_data_rd_grant | w_data_wr_grant;
  assign data_sram_data_ok = w_data_rret | w_bret;
  assign data_sram_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_arsize};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = r_arvalid;
  assign rready  = 1'b1;

  assign awid    = DATA_ID;
  assign awaddr  = r_awaddr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, r_awsize};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = r_awvalid;

  assign wid    = DATA_ID;
  assign wdata  = r_wdata;
  assign wstrb  = r_wstrb;
  assign wlast  = 1'b1;
  assign wvalid = r_wvalid;
  assign bready = r_bready;

  assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge: stimulus pushes expected AXI requests and SRAM
// responses into queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_sram_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  axi_sram_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_inst_aok = 0, cnt_data_aok = 0, cnt_inst_dok = 0, cnt_data_dok = 0;

  logic [38:0] exp_ar[$];   // {id, addr, arsize}
  logic [38:0] exp_aw[$];   // {id, addr, awsize}
  logic [35:0] exp_w[$];    // {wdata, wstrb}
  logic [31:0] exp_inst[$]; // inst rdata
  logic [32:0] exp_data[$]; // {is_write, rdata}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin : monitor
    logic [38:0] e_a;
    logic [35:0] e_w;
    logic [31:0] e_i;
    logic [32:0] e_d;
    if (aresetn) begin
      cnt_inst_aok += int'(inst_sram_addr_ok);
      cnt_data_aok += int'(data_sram_addr_ok);
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(araddr), 64'hffff_ffff_ffff);
        else begin
          e_a = exp_ar.pop_front();
          chk("ar_fields", 64'({arid, araddr, arsize}), 64'(e_a));
          chk("ar_len_burst", 64'({arlen, arburst}), 64'({8'd0, 2'b01}));
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(awaddr), 64'hffff_ffff_ffff);
        else begin
          e_a = exp_aw.pop_front();
          chk("aw_fields", 64'({awid, awaddr, awsize}), 64'(e_a));
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", 64'(wdata), 64'hffff_ffff_ffff);
        else begin
          e_w = exp_w.pop_front();
          chk("w_fields", 64'({wdata, wstrb}), 64'(e_w));
          chk("w_last_id", 64'({wlast, wid}), 64'({1'b1, 4'd1}));
        end
      end
      if (inst_sram_data_ok) begin
        cnt_inst_dok++;
        if (exp_inst.size() == 0) chk("inst_dok_unexpected", 64'(inst_sram_rdata), 64'hffff_ffff_ffff);
        else begin
          e_i = exp_inst.pop_front();
          chk("inst_rdata", 64'(inst_sram_rdata), 64'(e_i));
        end
      end
      if (data_sram_data_ok) begin
        cnt_data_dok++;
        if (exp_data.size() == 0) chk("data_dok_unexpected", 64'(data_sram_rdata), 64'hffff_ffff_ffff);
        else begin
          e_d = exp_data.pop_front();
          chk("data_dok_kind", 64'(bvalid && bready), 64'(e_d[32]));
          if (!e_d[32]) chk("data_rdata", 64'(data_sram_rdata), 64'(e_d[31:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ia, b_da, b_dd;
    aresetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset state
    cyc(2);
    @(negedge aclk);
    chk("rst_valids", 64'({arvalid, awvalid, wvalid, bready}), 64'd0);
    chk("rst_oks", 64'({inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}), 64'd0);
    chk("rst_rready", 64'(rready), 64'd1);
    cyc(1);
    aresetn = 1'b1;

    // Single instruction fetch, arready already high
    cyc(1);
    b_ia = cnt_inst_aok;
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2; arready = 1;
    exp_ar.push_back({4'd0, 32'h1c00_0000, 3'd2});
    @(negedge aclk);
    chk("t1_inst_aok", 64'(inst_sram_addr_ok), 64'd1);
    cyc(1);
    inst_sram_req = 0;
    cyc(1);
    arready = 0;
    cyc(2);
    rvalid = 1; rid = 4'd0; rdata = 32'h0280_0c06;
    exp_inst.push_back(32'h0280_0c06);
    cyc(1);
    rvalid = 0; rdata = 0;
    cyc(2);
    chk("t1_inst_aok_count", 64'(cnt_inst_aok - b_ia), 64'd1);
    chk("t1_arvalid_low", 64'(arvalid), 64'd0);

    // Same-cycle inst and data reads: data wins
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c00_8000; data_sram_size = 2'd2;
    arready = 1;
    exp_ar.push_back({4'd1, 32'h1c00_8000, 3'd2});
    exp_ar.push_back({4'd0, 32'h1c00_0010, 3'd2});
    @(negedge aclk);
    chk("t2_tie_aoks", 64'({data_sram_addr_ok, inst_sram_addr_ok}), 64'b10);
    cyc(1);
    data_sram_req = 0;
    @(negedge aclk);
    chk("t2_inst_wait", 64'(inst_sram_addr_ok), 64'd0);
    chk("t2_arid_data", 64'(arid), 64'd1);
    cyc(1);
    @(negedge aclk);
    chk("t2_inst_after_hs", 64'(inst_sram_addr_ok), 64'd1);
    cyc(1);
    inst_sram_req = 0;
    cyc(1);
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h1111_aaaa;
    exp_inst.push_back(32'h1111_aaaa);
    cyc(1);
    rid = 4'd1; rdata = 32'h2222_bbbb;
    exp_data.push_back({1'b0, 32'h2222_bbbb});
    cyc(1);
    rid = 4'd1; rdata = 32'hdead_0001;  // stray beat: no pend flag, must be dropped
    @(negedge aclk);
    chk("t2_stray_dropped", 64'(data_sram_data_ok), 64'd0);
    cyc(1);
    rvalid = 0; rdata = 0;

    // Byte store, awready two cycles after wready
    b_dd = cnt_data_dok;
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd0; data_sram_addr = 32'h1c00_8003;
    data_sram_wstrb = 4'b1000; data_sram_wdata = 32'h4400_0000;
    exp_aw.push_back({4'd1, 32'h1c00_8003, 3'd0});
    exp_w.push_back({32'h4400_0000, 4'b1000});
    @(negedge aclk);
    chk("t3_store_aok", 64'(data_sram_addr_ok), 64'd1);
    cyc(1);
    data_sram_req = 0; wready = 1;
    cyc(1);
    wready = 0;
    cyc(1);
    awready = 1;
    cyc(1);
    awready = 0;
    @(negedge aclk);
    chk("t3_bready_resp", 64'(bready), 64'd1);
    chk("t3_no_early_dok", 64'(cnt_data_dok - b_dd), 64'd0);
    cyc(1);
    bvalid = 1;
    exp_data.push_back({1'b1, 32'h0});
    cyc(1);
    bvalid = 0;
    @(negedge aclk);
    chk("t3_bready_idle", 64'(bready), 64'd0);
    chk("t3_dok_once", 64'(cnt_data_dok - b_dd), 64'd1);

    // Store pending, load waits for B handshake
    cyc(1);
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_addr = 32'h1c00_8010;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'h1234_5678; awready = 1; wready = 1;
    exp_aw.push_back({4'd1, 32'h1c00_8010, 3'd2});
    exp_w.push_back({32'h1234_5678, 4'hf});
    cyc(1);
    data_sram_wr = 0; data_sram_addr = 32'h1c00_8020;
    b_da = cnt_data_aok;
    cyc(1);
    awready = 0; wready = 0;
    cyc(1);
    bvalid = 1;
    exp_data.push_back({1'b1, 32'h0});
    @(negedge aclk);
    chk("t4_load_blocked", 64'(cnt_data_aok - b_da), 64'd0);
    cyc(1);
    bvalid = 0;
    exp_ar.push_back({4'd1, 32'h1c00_8020, 3'd2});
    @(negedge aclk);
    chk("t4_load_aok", 64'({data_sram_addr_ok, arvalid}), 64'b10);
    cyc(1);
    data_sram_req = 0; arready = 1;
    @(negedge aclk);
    chk("t4_arvalid_rise", 64'(arvalid), 64'd1);
    cyc(1);
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'hcafe_0001;
    exp_data.push_back({1'b0, 32'hcafe_0001});
    cyc(1);
    rvalid = 0; rdata = 0;

    // arready held low: fields stable, no further accepts
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100;
    cyc(1);
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c00_8100;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t5_ar_stable", 64'({arvalid, arid, araddr}), 64'({1'b1, 4'd0, 32'h1c00_0100}));
      chk("t5_no_aok", 64'({inst_sram_addr_ok, data_sram_addr_ok}), 64'd0);
      cyc(1);
    end
    arready = 1;
    exp_ar.push_back({4'd0, 32'h1c00_0100, 3'd2});
    cyc(1);
    arready = 0;
    exp_ar.push_back({4'd1, 32'h1c00_8100, 3'd2});
    @(negedge aclk);
    chk("t5_data_after", 64'({data_sram_addr_ok, inst_sram_addr_ok}), 64'b10);
    cyc(1);
    data_sram_req = 0; inst_sram_req = 0; arready = 1;
    cyc(1);
    arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h5555_0002;
    exp_data.push_back({1'b0, 32'h5555_0002});
    cyc(1);
    rid = 4'd0; rdata = 32'h6666_0003;
    exp_inst.push_back(32'h6666_0003);
    cyc(1);
    rvalid = 0; rdata = 0;

    // Reset during AR_BUSY and W_SEND
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c00_8200;
    cyc(1);
    data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0200;
    cyc(1);
    inst_sram_req = 0;
    @(negedge aclk);
    chk("t6_busy_valids", 64'({arvalid, awvalid, wvalid}), 64'b111);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_async_drop", 64'({arvalid, awvalid, wvalid}), 64'd0);
    cyc(2);
    aresetn = 1'b1;
    cyc(1);
    rvalid = 1; rid = 4'd1; rdata = 32'hbad0_0001;
    @(negedge aclk);
    chk("t6_late_r_dropped", 64'({data_sram_data_ok, inst_sram_data_ok}), 64'd0);
    cyc(1);
    rvalid = 0;
    cyc(2);

    chk("end_queues_empty", 64'(exp_ar.size() + exp_aw.size() + exp_w.size()
                                + exp_inst.size() + exp_data.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
